// File: rtl/dataflow_supervisor_pkg.sv
// Shared definitions for the UART loader/supervisor: command codes, mode decode
// and the state encodings of the supervisor and the UART engines.
package dataflow_supervisor_pkg;

    localparam logic [7:0]  CMD_ROM_DUMP = 8'hFF;
    localparam logic [7:0]  CMD_LINE_MAX = 8'h0F;
    localparam int unsigned NPU_LINES    = 16;

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_ROM_LOAD,
        MODE_NPU_LOAD,
        MODE_RUN
    } mode_e;

    typedef enum logic [2:0] {
        SUP_IDLE,
        SUP_ECHO,
        SUP_DUMP_ROM,
        SUP_DUMP_SUM,
        SUP_DUMP_CNT,
        SUP_DUMP_LINE
    } sup_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    function automatic mode_e decode_mode(input logic run_sel, input logic rom_sel,
                                          input logic npu_sel);
        if (run_sel) return MODE_RUN;
        if (rom_sel) return MODE_ROM_LOAD;
        if (npu_sel) return MODE_NPU_LOAD;
        return MODE_IDLE;
    endfunction

    function automatic int unsigned npu_addr(input logic [3:0] line, input int unsigned offset,
                                             input int unsigned line_bytes);
        return 32'(line) * line_bytes + offset;
    endfunction

endpackage

// File: rtl/dataflow_supervisor_uart_core.sv
// 8N1 UART receiver and transmitter sharing one bit period of CLKS_PER_BIT cycles.
module uart_core
    import dataflow_supervisor_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       uart_i,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       uart_o
);

    localparam int unsigned    CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [2:0]    rx_sync;
    logic          rx_line;
    logic          rx_prev;
    rx_state_e     rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;

    tx_state_e     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    // rx_sync[1] is the synchronised line, rx_sync[2] its previous value for edge detection
    assign rx_line = rx_sync[1];
    assign rx_prev = rx_sync[2];
    assign rx_data = rx_shift;
    assign tx_busy = (tx_state != TX_IDLE);

    always_comb begin
        rx_next  = rx_state;
        rx_valid = 1'b0;
        unique case (rx_state)
            RX_IDLE:      if (rx_prev && !rx_line) rx_next = RX_START;
            RX_START:     if (rx_cnt == CNT_HALF) rx_next = rx_line ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_cnt == CNT_LAST && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (rx_cnt == CNT_LAST) begin
                    if (rx_line) begin
                        rx_valid = 1'b1;
                        rx_next  = RX_IDLE;
                    end else begin
                        rx_next  = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: if (rx_line) rx_next = RX_IDLE;
            default:      rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rx_sync  <= '1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync  <= {rx_sync[1:0], uart_i};
            rx_state <= rx_next;
            if (rx_state != rx_next || rx_cnt == CNT_LAST) rx_cnt <= '0;
            else                                           rx_cnt <= rx_cnt + CW'(1);
            if (rx_state == RX_START) rx_bit <= '0;
            if (rx_state == RX_DATA && rx_cnt == CNT_LAST) begin
                rx_shift <= {rx_line, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end
    end

    always_comb begin
        tx_next = tx_state;
        uart_o  = 1'b1;
        unique case (tx_state)
            TX_IDLE:  if (tx_start) tx_next = TX_START;
            TX_START: begin
                uart_o = 1'b0;
                if (tx_cnt == CNT_LAST) tx_next = TX_DATA;
            end
            TX_DATA: begin
                uart_o = tx_shift[0];
                if (tx_cnt == CNT_LAST && tx_bit == 3'd7) tx_next = TX_STOP;
            end
            TX_STOP:  if (tx_cnt == CNT_LAST) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_state != tx_next || tx_cnt == CNT_LAST) tx_cnt <= '0;
            else                                           tx_cnt <= tx_cnt + CW'(1);
            if (tx_state == TX_IDLE && tx_start) begin
                tx_shift <= tx_data;
                tx_bit   <= '0;
            end else if (tx_state == TX_DATA && tx_cnt == CNT_LAST) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
        end
    end

endmodule

// File: rtl/dataflow_supervisor.sv
// UART loader/supervisor: loads program ROM and NPU lines from the host, echoes
// loaded bytes and serves ROM/line readback commands in run mode.
module dataflow_supervisor
    import dataflow_supervisor_pkg::*;
#(
    parameter int unsigned CLK_rate       = 100000000,
    parameter int unsigned Baud_rate      = 9600,
    parameter int unsigned MAX_SIZE       = 2500,
    parameter int unsigned NPU_LINE_BYTES = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rst_rom_i,
    input  logic       rst_uart_i,
    input  logic       mode_sel_i,
    input  logic       rom_en_w_sel_i,
    input  logic       npu_ram_en_w_sel_i,
    input  logic [3:0] npu_ram_w_line_i,
    input  logic       uart_i,
    output logic       uart_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_rate / Baud_rate;
    localparam int unsigned LW        = $clog2(MAX_SIZE + 1);
    localparam int unsigned RAW       = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
    localparam int unsigned OW        = $clog2(NPU_LINE_BYTES + 1);
    localparam int unsigned NPU_DEPTH = NPU_LINES * NPU_LINE_BYTES;
    localparam int unsigned NAW       = $clog2(NPU_DEPTH);
    localparam logic [LW-1:0] ROM_FULL  = LW'(MAX_SIZE);
    localparam logic [OW-1:0] LINE_FULL = OW'(NPU_LINE_BYTES);

    logic          uart_rst_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
    mode_e         mode;

    logic [7:0]    rom [MAX_SIZE];
    logic [7:0]    npu [NPU_DEPTH];
    logic [LW-1:0] rom_len;
    logic [OW-1:0] off [NPU_LINES];
    logic          rom_we, npu_we;
    logic [7:0]    rom_rdata, npu_rdata;

    logic          echo_full, echo_req, echo_take;
    logic [7:0]    echo_data;

    sup_state_e    state, state_next;
    logic [LW-1:0] rom_idx, rom_idx_next;
    logic [7:0]    sum, sum_next;
    logic [3:0]    dump_line, dump_line_next;
    logic [OW-1:0] line_idx, line_idx_next;
    logic          cmd_valid;

    assign uart_rst_n = rst_i & rst_uart_i;
    assign mode       = decode_mode(mode_sel_i, rom_en_w_sel_i, npu_ram_en_w_sel_i);

    uart_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk_i   (clk_i),
        .rst_n   (uart_rst_n),
        .uart_i  (uart_i),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_busy (tx_busy),
        .uart_o  (uart_o)
    );

    always_comb begin
        rom_we    = rx_valid && mode == MODE_ROM_LOAD && rom_len != ROM_FULL;
        npu_we    = rx_valid && mode == MODE_NPU_LOAD && off[npu_ram_w_line_i] != LINE_FULL;
        echo_req  = rx_valid && (mode == MODE_ROM_LOAD || mode == MODE_NPU_LOAD);
        cmd_valid = rx_valid && mode == MODE_RUN;
        rom_rdata = rom[RAW'(rom_idx)];
        npu_rdata = npu[NAW'(npu_addr(dump_line, 32'(line_idx), NPU_LINE_BYTES))];
    end

    always_ff @(posedge clk_i) begin
        if (rom_we) rom[RAW'(rom_len)] <= rx_data;
        if (npu_we)
            npu[NAW'(npu_addr(npu_ram_w_line_i, 32'(off[npu_ram_w_line_i]), NPU_LINE_BYTES))] <= rx_data;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i || !rst_rom_i) rom_len <= '0;
        else if (rom_we)          rom_len <= rom_len + LW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < NPU_LINES; i++) off[i] <= '0;
        end else if (npu_we) begin
            off[npu_ram_w_line_i] <= off[npu_ram_w_line_i] + OW'(1);
        end
    end

    // A byte arriving while the holding register is occupied loses its echo only.
    always_ff @(posedge clk_i) begin
        if (!uart_rst_n) begin
            echo_full <= 1'b0;
            echo_data <= '0;
        end else if (echo_req && !echo_full) begin
            echo_full <= 1'b1;
            echo_data <= rx_data;
        end else if (echo_take) begin
            echo_full <= 1'b0;
        end
    end

    always_comb begin
        state_next     = state;
        rom_idx_next   = rom_idx;
        sum_next       = sum;
        dump_line_next = dump_line;
        line_idx_next  = line_idx;
        tx_start       = 1'b0;
        tx_data        = echo_data;
        echo_take      = 1'b0;
        unique case (state)
            SUP_IDLE: begin
                if (cmd_valid && rx_data == CMD_ROM_DUMP) begin
                    state_next   = SUP_DUMP_ROM;
                    rom_idx_next = '0;
                    sum_next     = '0;
                end else if (cmd_valid && rx_data <= CMD_LINE_MAX) begin
                    state_next     = SUP_DUMP_CNT;
                    dump_line_next = rx_data[3:0];
                end else if (echo_full && !tx_busy) begin
                    tx_start   = 1'b1;
                    echo_take  = 1'b1;
                    state_next = SUP_ECHO;
                end
            end
            SUP_ECHO: state_next = SUP_IDLE;
            SUP_DUMP_ROM: begin
                if (rom_idx >= rom_len) begin
                    state_next = SUP_DUMP_SUM;
                end else if (!tx_busy) begin
                    tx_start     = 1'b1;
                    tx_data      = rom_rdata;
                    sum_next     = sum ^ rom_rdata;
                    rom_idx_next = rom_idx + LW'(1);
                end
            end
            SUP_DUMP_SUM: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    tx_data    = sum;
                    state_next = SUP_IDLE;
                end
            end
            SUP_DUMP_CNT: begin
                if (!tx_busy) begin
                    tx_start      = 1'b1;
                    tx_data       = 8'(off[dump_line]);
                    line_idx_next = '0;
                    state_next    = SUP_DUMP_LINE;
                end
            end
            SUP_DUMP_LINE: begin
                if (line_idx >= off[dump_line]) begin
                    state_next = SUP_IDLE;
                end else if (!tx_busy) begin
                    tx_start      = 1'b1;
                    tx_data       = npu_rdata;
                    line_idx_next = line_idx + OW'(1);
                end
            end
            default: state_next = SUP_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= SUP_IDLE;
            rom_idx   <= '0;
            sum       <= '0;
            dump_line <= '0;
            line_idx  <= '0;
        end else begin
            state     <= state_next;
            rom_idx   <= rom_idx_next;
            sum       <= sum_next;
            dump_line <= dump_line_next;
            line_idx  <= line_idx_next;
        end
    end

endmodule

// File: tb/tb_dataflow_supervisor.sv
// Self-checking bench: host bytes are driven serially, uart_o is decoded by a
// monitor and compared against a queue/array model of ROM and NPU line contents.
module tb_dataflow_supervisor;

    localparam int CLKS = 16;
    localparam int MAXS = 2;
    localparam int LB   = 8;

    logic       clk_i = 1'b0;
    logic       rst_i, rst_rom_i, rst_uart_i;
    logic       mode_sel_i, rom_en_w_sel_i, npu_ram_en_w_sel_i;
    logic [3:0] npu_ram_w_line_i;
    logic       uart_i, uart_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int rxq[$];
    int stq[$];
    int expq[$];

    int rom_m [MAXS];
    int rom_cnt;
    int npu_m [16][LB];
    int npu_cnt [16];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    dataflow_supervisor #(
        .CLK_rate      (16),
        .Baud_rate     (1),
        .MAX_SIZE      (MAXS),
        .NPU_LINE_BYTES(LB)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .rst_rom_i         (rst_rom_i),
        .rst_uart_i        (rst_uart_i),
        .mode_sel_i        (mode_sel_i),
        .rom_en_w_sel_i    (rom_en_w_sel_i),
        .npu_ram_en_w_sel_i(npu_ram_en_w_sel_i),
        .npu_ram_w_line_i  (npu_ram_w_line_i),
        .uart_i            (uart_i),
        .uart_o            (uart_o)
    );

    // Frame decoder on uart_o; a start bit that is high at its centre is discarded.
    initial begin : tx_monitor
        logic       prev;
        logic [7:0] d;
        int         st;
        prev = 1'b1;
        forever begin
            @(negedge clk_i);
            if (prev === 1'b1 && uart_o === 1'b0) begin
                st = cyc;
                repeat (CLKS / 2) @(negedge clk_i);
                if (uart_o === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CLKS) @(negedge clk_i);
                        d[i] = uart_o;
                    end
                    repeat (CLKS) @(negedge clk_i);
                    rxq.push_back((uart_o === 1'b1) ? int'(d) : 256 + int'(d));
                    stq.push_back(st);
                end
            end
            prev = uart_o;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        @(posedge clk_i); #1;
        for (int i = 0; i < 10; i++) begin
            uart_i = fr[i];
            repeat (CLKS) @(posedge clk_i);
            #1;
        end
        if (!stop_ok) begin
            repeat (2 * CLKS) @(posedge clk_i);
            #1;
        end
        uart_i = 1'b1;
    endtask

    task automatic expect_tx(input string tag);
        int n;
        n = expq.size();
        for (int w = 0; w < (n + 1) * 12 * CLKS && rxq.size() < n; w++) @(negedge clk_i);
        repeat (12 * CLKS) @(negedge clk_i);
        check({tag, "_count"}, rxq.size(), n);
        for (int i = 0; i < n && i < rxq.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), rxq[i], expq[i]);
            if (i > 0)
                check($sformatf("%s_gap%0d", tag, i),
                      (stq[i] - stq[i-1] >= 10 * CLKS && stq[i] - stq[i-1] <= 10 * CLKS + 1) ? 1 : 0, 1);
        end
        rxq.delete();
        stq.delete();
        expq.delete();
    endtask

    // Derive the expected host-visible response from the mode rules, then send.
    task automatic host_byte(input string tag, input int b);
        int x;
        int line;
        if (mode_sel_i) begin
            if (b == 'hFF) begin
                x = 0;
                for (int i = 0; i < rom_cnt; i++) begin
                    expq.push_back(rom_m[i]);
                    x ^= rom_m[i];
                end
                expq.push_back(x);
            end else if (b <= 'h0F) begin
                expq.push_back(npu_cnt[b]);
                for (int i = 0; i < npu_cnt[b]; i++) expq.push_back(npu_m[b][i]);
            end
        end else if (rom_en_w_sel_i) begin
            expq.push_back(b);
            if (rom_cnt < MAXS) begin
                rom_m[rom_cnt] = b;
                rom_cnt++;
            end
        end else if (npu_ram_en_w_sel_i) begin
            line = int'(npu_ram_w_line_i);
            expq.push_back(b);
            if (npu_cnt[line] < LB) begin
                npu_m[line][npu_cnt[line]] = b;
                npu_cnt[line]++;
            end
        end
        send_frame(8'(b), 1'b1);
        expect_tx(tag);
    endtask

    task automatic set_mode(input logic m, input logic r, input logic n, input logic [3:0] line);
        mode_sel_i         = m;
        rom_en_w_sel_i     = r;
        npu_ram_en_w_sel_i = n;
        npu_ram_w_line_i   = line;
    endtask

    task automatic pulse_rom_rst();
        @(posedge clk_i); #1;
        rst_rom_i = 1'b0;
        @(posedge clk_i); #1;
        rst_rom_i = 1'b1;
        rom_cnt = 0;
    endtask

    initial begin
        rst_i = 1'b0;
        rst_rom_i = 1'b1;
        rst_uart_i = 1'b1;
        uart_i = 1'b1;
        set_mode(1'b0, 1'b0, 1'b0, 4'd0);
        rom_cnt = 0;
        for (int i = 0; i < 16; i++) npu_cnt[i] = 0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        check("reset_uart_o", int'(uart_o), 1);
        repeat (4 * CLKS) @(posedge clk_i);

        host_byte("idle_ignore", 'h55);

        set_mode(1'b0, 1'b1, 1'b0, 4'd0);
        host_byte("rom_echo0", 'h12);
        host_byte("rom_echo1", 'h34);
        set_mode(1'b1, 1'b0, 1'b0, 4'd0);
        host_byte("rom_dump", 'hFF);

        set_mode(1'b1, 1'b1, 1'b0, 4'd0);
        host_byte("prio_cmd", 'h10);
        host_byte("prio_dump", 'hFF);

        pulse_rom_rst();
        set_mode(1'b0, 1'b1, 1'b0, 4'd0);
        host_byte("sat_echo0", 'hA1);
        host_byte("sat_echo1", 'hA2);
        host_byte("sat_echo2", 'hA3);
        set_mode(1'b1, 1'b0, 1'b0, 4'd0);
        host_byte("sat_dump", 'hFF);

        pulse_rom_rst();
        host_byte("romrst_dump", 'hFF);

        set_mode(1'b0, 1'b0, 1'b1, 4'd5);
        host_byte("npu_l5a", 'h01);
        host_byte("npu_l5b", 'h02);
        npu_ram_w_line_i = 4'd3;
        host_byte("npu_l3", 'h09);
        npu_ram_w_line_i = 4'd5;
        host_byte("npu_l5c", 'h0A);
        set_mode(1'b1, 1'b0, 1'b0, 4'd0);
        host_byte("npu_dump5", 'h05);
        host_byte("npu_dump3", 'h03);

        set_mode(1'b0, 1'b0, 1'b1, 4'd15);
        for (int i = 0; i < LB + 2; i++) host_byte("fill_l15", int'($urandom_range(0, 255)));
        for (int i = 0; i < 20; i++) begin
            npu_ram_w_line_i = 4'($urandom_range(0, 15));
            host_byte("rnd_load", int'($urandom_range(0, 255)));
        end
        set_mode(1'b1, 1'b0, 1'b0, 4'd0);
        for (int l = 0; l < 16; l++) host_byte($sformatf("dump_line%0d", l), l);
        for (int i = 0; i < 3; i++) host_byte("bad_cmd", int'($urandom_range(16, 254)));

        pulse_rom_rst();
        set_mode(1'b0, 1'b1, 1'b0, 4'd0);
        send_frame(8'h77, 1'b1);
        rom_m[rom_cnt] = 'h77;
        rom_cnt++;
        for (int w = 0; w < 4 * CLKS && uart_o !== 1'b0; w++) @(negedge clk_i);
        check("uartrst_pre", int'(uart_o), 0);
        @(posedge clk_i); #1;
        rst_uart_i = 1'b0;
        @(posedge clk_i); #1;
        check("uartrst_uart_o", int'(uart_o), 1);
        rst_uart_i = 1'b1;
        expect_tx("uartrst_quiet");

        pulse_rom_rst();
        send_frame(8'h3C, 1'b0);
        expect_tx("frame_bad");
        host_byte("frame_good", 'hC3);
        set_mode(1'b1, 1'b0, 1'b0, 4'd0);
        host_byte("frame_dump", 'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dataflow_supervisor.md
# dataflow_supervisor

UART-driven loader and supervisor that sits between the board wrapper's switches, buttons and UART pins and the on-chip program store and NPU line store. Depending on the selected mode, it either writes received bytes into an internal program ROM buffer or an NPU RAM line, echoing each byte, or serves readback requests in run mode. It is the only path by which host data enters or leaves the design.

## Interface
- CLK_rate, 100000000: clock frequency in Hz.
- Baud_rate, 9600: UART bit rate; CLKS_PER_BIT = CLK_rate/Baud_rate (integer divide, must be ≥ 4).
- MAX_SIZE, 2500: ROM depth in bytes.
- NPU_LINE_BYTES, 64: bytes per NPU line (16 lines).
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-low global reset.
- rst_rom_i  in  1  synchronous, active-low; clears rom_len only.
- rst_uart_i  in  1  synchronous, active-low; resets the UART RX and TX state machines and the echo holding register.
- mode_sel_i  in  1  run mode.
- rom_en_w_sel_i  in  1  ROM load mode.
- npu_ram_en_w_sel_i  in  1  NPU RAM load mode.
- npu_ram_w_line_i  in  4  NPU target line for load mode.
- uart_i  in  1  serial RX, 8N1, idle high.
- uart_o  out  1  serial TX, 8N1; idles high.

## Operation
- Mode priority, evaluated when an RX byte completes:
  - mode_sel_i, then rom_en_w_sel_i, then npu_ram_en_w_sel_i.
  - None of these set: idle; the byte is discarded with no echo.
- ROM load:
  - Byte is written to rom[rom_len], then rom_len increments.
  - At rom_len == MAX_SIZE the byte is dropped and rom_len saturates.
  - Byte is echoed in both cases.
- NPU load:
  - Byte is written to npu[line][off[line]], then off[line] increments.
  - Writes at off == NPU_LINE_BYTES are dropped; byte still echoed.
  - Changing the line keeps the per-line offsets.
- Run mode: each RX byte is a command; no echo.
  - 0xFF: transmit rom[0..rom_len-1], then one byte equal to the XOR of those bytes (0x00 if rom_len is 0).
  - 0x00–0x0F: transmit off[line] as one byte, then that line's written bytes in order.
  - Any other value is ignored.
  - RX bytes arriving during a dump are ignored.
- UART RX:
  - Detects the falling edge of the start bit and re-checks it low at the half-bit point; a high re-check is a glitch and returns to idle.
  - Samples data LSB first at bit centres.
  - A stop bit sampled low is a framing error: the byte is dropped and the block waits for uart_i to return high.
- Echo path: one-byte holding register. If it is still full when a new byte needs echoing, the new echo is dropped; storage is unaffected.
- Reset values:
  - rst_i: uart_o=1, rom_len=0, all off[]=0, UART idle, no dump in progress. ROM and NPU contents undefined.
  - rst_rom_i: rom_len=0 only.
  - rst_uart_i: a frame in flight is aborted and uart_o=1 on the next cycle.
- Simultaneous resets: rst_i dominates.

## Timing
- RX byte valid is a one-cycle strobe at the centre of the stop bit. The store write happens on the same edge.
- For an echo, the TX start bit begins ≤ 3 cycles after the RX strobe.
- Each TX bit lasts exactly CLKS_PER_BIT cycles, and the stop bit is held for a full bit.
- Dump bytes are sent back-to-back: the next start bit directly follows the previous stop bit, with at most 1 idle cycle between.
- A new ROM write lands at rom[rom_len] in the cycle after rst_rom_i deasserts.

## Structure
- Shared package holds the command codes (CMD_ROM_DUMP=0xFF, line range 0x00–0x0F), NPU_LINES=16 and the mode encoding enum (IDLE, ROM_LOAD, NPU_LOAD, RUN).
- Sub-modules:
  - uart_core (rx+tx, parameterised by CLKS_PER_BIT): the natural split.
  - Supervisor FSM with states IDLE, ECHO, DUMP_ROM, DUMP_SUM, DUMP_CNT, DUMP_LINE; it and the storage arrays stay in the top.

## Test plan
All scenarios use CLK_rate=16, Baud_rate=1, so CLKS_PER_BIT=16.
- ROM load: rom_en_w_sel_i=1, send 0x12, 0x34 → both echoed; then mode_sel_i=1, send 0xFF → TX 0x12, 0x34, 0x26.
- Saturation: MAX_SIZE=2, send 0xA1, 0xA2, 0xA3 → three echoes; 0xFF dump returns 0xA1, 0xA2, 0x03.
- NPU load: line 5, send 0x01, 0x02; line 3, send 0x09; line 5, send 0x0A → run-mode 0x05 returns 0x03, 0x01, 0x02, 0x0A, and 0x03 returns 0x01, 0x09.
- Priority and idle:
  - All selects low: send 0x55 → no TX activity.
  - mode_sel_i and rom_en_w_sel_i both high: send 0x10 → ignored, no echo, rom_len unchanged.
- Resets:
  - Pulse rst_rom_i low for 1 cycle after loading 3 bytes → 0xFF dump returns only 0x00.
  - rst_uart_i mid-echo → uart_o is 1 the next cycle.
- Framing: a frame with its stop bit low → no store, no echo; the next good frame is handled normally.
